operand_fwd_stage: RTL and testbench
====================================

OPERAND_FWD_STAGE -- requirements
Module: operand_fwd_stage

Interface
REQ-001 Parameter XLEN, default 32: operand and data width.
REQ-002 Parameter CNT_W, default 16: width of the load-use stall counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  synchronous pipeline flush.
REQ-006 in_valid  in  1  IDU holds an instruction whose operands are to be resolved.
REQ-007 in_ready  out  1  the stage accepts the IDU instruction this cycle.
REQ-008 rs1_choice, rs2_choice  in  3 each  forwarding-source codes from the hazard arbiter.
REQ-009 rf_rdata1, rf_rdata2  in  XLEN each  register-file read data.
REQ-010 exu_result  in  XLEN  EXU ALU result.
REQ-011 wbu_wdata  in  XLEN  WBU write-back data.
REQ-012 mem_alu_result  in  XLEN  MEM-stage ALU result for a non-load instruction.
REQ-013 mem_rdata, mem_rdata_valid  in  XLEN, 1  MEM-stage load data and its qualifier.
REQ-014 out_valid, out_ready  out, in  1, 1  EXU-side valid/ready handshake.
REQ-015 out_src1, out_src2  out  XLEN each  resolved operands; stable while out_valid=1 and out_ready=0.
REQ-016 ldu_stall_cnt  out  CNT_W  saturating count of cycles spent waiting on load data.
REQ-017 illegal_choice  out  1  sticky flag for an illegal choice code.

Function
REQ-018 Choice decode: 000 = rf_rdata, 001 = exu_result, 010 = wbu_wdata, 011 = mem_rdata (load-use), 100 = mem_alu_result.
REQ-019 Codes 101-111 select rf_rdata and set illegal_choice on acceptance.
REQ-020 States: EMPTY (no operand held), WAIT (accepted, at least one operand awaiting load data), FULL (out_valid=1).
REQ-021 in_ready = (state==EMPTY or (state==FULL and out_ready)) and not flush; in_ready is 0 in WAIT.
REQ-022 Accept = in_valid and in_ready.
REQ-023 On accept, each operand whose choice is not 011 is captured in the same edge.
REQ-024 On accept, a choice-011 operand is captured in the same edge only if mem_rdata_valid=1; otherwise a per-operand pending bit is set.
REQ-025 On accept: next state is WAIT if any pending bit is set, else FULL; a zero-bubble EMPTY->FULL transition is required when no load-use is present.
REQ-026 If rs1 and rs2 both use choice 011, both take mem_rdata on the same mem_rdata_valid cycle.
REQ-027 In WAIT with mem_rdata_valid=1: every pending operand captures mem_rdata, pending bits clear, state -> FULL; out_valid rises the following cycle.
REQ-028 In WAIT with mem_rdata_valid=0: state holds and ldu_stall_cnt increments by 1, saturating at 2^CNT_W-1.
REQ-029 In FULL with out_ready=1 and no accept: state -> EMPTY.
REQ-030 In FULL with out_ready=1 and an accept: the new instruction replaces the old one back-to-back, following REQ-023 to REQ-025.
REQ-031 In FULL with out_ready=0: out_src1 and out_src2 hold.
REQ-032 flush=1 has top priority in every state: next state EMPTY, pending bits cleared, no capture, counters unchanged.
REQ-033 Output latency is one cycle from accept to out_valid when no load-use is present.

Reset
REQ-034 rst_n=0 asynchronously forces: state EMPTY, out_valid 0, out_src1 and out_src2 0, pending bits 0, ldu_stall_cnt 0, illegal_choice 0.
REQ-035 Reset asserted in WAIT or FULL discards the held instruction with no partial output.
REQ-036 After rst_n deasserts, the first edge may accept (in_ready=1).

Structure
REQ-037 Shared package op_fwd_pkg holds the choice encodings (FWD_RF, FWD_EXU, FWD_WBU, FWD_MEM_LD, FWD_MEM_ALU) and the state enum; the package is shared with the hazard arbiter.
REQ-038 Sub-module operand_sel (a 5-input XLEN mux driven by a choice code) is instantiated once per operand.
REQ-039 The state register, the pending bits, the operand registers and the counter live in operand_fwd_stage.

Verification
REQ-040 No hazard: choices 000/000, rf_rdata1=0x11, rf_rdata2=0x22, out_ready=1 -> out_valid next cycle, srcs 0x11/0x22, ldu_stall_cnt=0.
REQ-041 Forward mix: rs1_choice=001 with exu_result=0xAA; rs2_choice=100 with mem_alu_result=0xBB -> srcs 0xAA/0xBB after 1 cycle.
REQ-042 Load-use: rs2_choice=011, mem_rdata_valid low for 3 cycles, then mem_rdata=0xDEAD with valid -> state WAIT for 3 cycles, ldu_stall_cnt=3, out_src2=0xDEAD; out_src1 is the value captured at accept.
REQ-043 Backpressure and back-to-back: out_ready=0 for 2 cycles -> outputs hold and in_ready=0; then out_ready=1 with in_valid=1 -> next instruction captured the same edge with no bubble.
REQ-044 Flush in WAIT: flush=1 -> EMPTY the next cycle, out_valid=0; a later mem_rdata_valid captures nothing.
REQ-045 Illegal and reset: rs1_choice=110 -> rf_rdata1 selected, illegal_choice=1 sticky; asynchronous rst_n low mid-FULL -> all outputs 0 immediately.

Source files
------------

// File: rtl/op_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : op_fwd_pkg
// Description : Forwarding-source choice codes and operand-stage state
//               encoding, shared between the operand stage and the hazard
//               arbiter that produces the choice codes.
// Revision    : 1.0 - initial release
// ============================================================================
package op_fwd_pkg;

  // Forwarding-source choice codes
  localparam logic [2:0] FWD_RF      = 3'b000;
  localparam logic [2:0] FWD_EXU     = 3'b001;
  localparam logic [2:0] FWD_WBU     = 3'b010;
  localparam logic [2:0] FWD_MEM_LD  = 3'b011;
  localparam logic [2:0] FWD_MEM_ALU = 3'b100;

  // Operand stage occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } fwd_state_t;

  // Codes above the last defined source are reserved
  function automatic logic is_illegal_choice(input logic [2:0] choice);
    return (choice > FWD_MEM_ALU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_sel.sv
`default_nettype none
// ============================================================================
// Module      : operand_sel
// Description : Five-way operand source mux driven by a forwarding choice
//               code. Reserved codes fall back to register-file data and
//               raise o_illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_sel
  import op_fwd_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_choice,
  input  logic [XLEN-1:0] i_rf_rdata,
  input  logic [XLEN-1:0] i_exu_result,
  input  logic [XLEN-1:0] i_wbu_wdata,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic [XLEN-1:0] i_mem_alu_result,
  output logic [XLEN-1:0] o_operand,
  output logic            o_illegal
);

  // Select the operand source; reserved codes read the register file
  always_comb begin
    o_operand = i_rf_rdata;
    o_illegal = is_illegal_choice(i_choice);
    case (i_choice)
      FWD_EXU:     o_operand = i_exu_result;
      FWD_WBU:     o_operand = i_wbu_wdata;
      FWD_MEM_LD:  o_operand = i_mem_rdata;
      FWD_MEM_ALU: o_operand = i_mem_alu_result;
      default:     o_operand = i_rf_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/operand_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_stage
// Description : Resolves both source operands of an IDU instruction from the
//               register file or a forwarding path, waits for load data on a
//               load-use hazard, and presents the operands to the EXU with a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_stage
  import op_fwd_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       rs1_choice,
  input  logic [2:0]       rs2_choice,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  input  logic [XLEN-1:0]  exu_result,
  input  logic [XLEN-1:0]  wbu_wdata,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_rdata_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_src1,
  output logic [XLEN-1:0]  out_src2,
  output logic [CNT_W-1:0] ldu_stall_cnt,
  output logic             illegal_choice
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  fwd_state_t       r_state;
  logic             r_out_valid;
  logic             r_pend1;
  logic             r_pend2;
  logic [XLEN-1:0]  r_src1;
  logic [XLEN-1:0]  r_src2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;

  logic [XLEN-1:0]  w_sel1;
  logic [XLEN-1:0]  w_sel2;
  logic             w_ill1;
  logic             w_ill2;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_pend1_new;
  logic             w_pend2_new;

  operand_sel #(.XLEN(XLEN)) u_sel_rs1 (
    .i_choice         (rs1_choice),
    .i_rf_rdata       (rf_rdata1),
    .i_exu_result     (exu_result),
    .i_wbu_wdata      (wbu_wdata),
    .i_mem_rdata      (mem_rdata),
    .i_mem_alu_result (mem_alu_result),
    .o_operand        (w_sel1),
    .o_illegal        (w_ill1)
  );

  operand_sel #(.XLEN(XLEN)) u_sel_rs2 (
    .i_choice         (rs2_choice),
    .i_rf_rdata       (rf_rdata2),
    .i_exu_result     (exu_result),
    .i_wbu_wdata      (wbu_wdata),
    .i_mem_rdata      (mem_rdata),
    .i_mem_alu_result (mem_alu_result),
    .o_operand        (w_sel2),
    .o_illegal        (w_ill2)
  );

  // Accept when empty, or when the held result leaves this same cycle
  assign w_in_ready  = ((r_state == ST_EMPTY) ||
                        ((r_state == ST_FULL) && out_ready)) && !flush;
  assign w_accept    = in_valid && w_in_ready;
  // A load-use operand without load data this cycle must wait in WAIT
  assign w_pend1_new = (rs1_choice == FWD_MEM_LD) && !mem_rdata_valid;
  assign w_pend2_new = (rs2_choice == FWD_MEM_LD) && !mem_rdata_valid;

  // Stage FSM: occupancy, operand capture, load-wait counting, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_pend1     <= 1'b0;
      r_pend2     <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_cnt       <= '0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_pend1     <= 1'b0;
      r_pend2     <= 1'b0;
    end else if (w_accept) begin
      if (!w_pend1_new) r_src1 <= w_sel1;
      if (!w_pend2_new) r_src2 <= w_sel2;
      r_pend1 <= w_pend1_new;
      r_pend2 <= w_pend2_new;
      if (w_ill1 || w_ill2) r_illegal <= 1'b1;
      if (w_pend1_new || w_pend2_new) begin
        r_state     <= ST_WAIT;
        r_out_valid <= 1'b0;
      end else begin
        r_state     <= ST_FULL;
        r_out_valid <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (mem_rdata_valid) begin
            if (r_pend1) r_src1 <= mem_rdata;
            if (r_pend2) r_src2 <= mem_rdata;
            r_pend1     <= 1'b0;
            r_pend2     <= 1'b0;
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
          end else if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_EMPTY: begin
          r_state <= ST_EMPTY;
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = w_in_ready;
  assign out_valid      = r_out_valid;
  assign out_src1       = r_src1;
  assign out_src2       = r_src2;
  assign ldu_stall_cnt  = r_cnt;
  assign illegal_choice = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_operand_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fwd_stage
// Description : Scoreboard bench for operand_fwd_stage: directed scenarios
//               plus randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fwd_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 3;
  localparam int C_CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       rs1_choice = 3'd0;
  logic [2:0]       rs2_choice = 3'd0;
  logic [XLEN-1:0]  rf_rdata1 = '0;
  logic [XLEN-1:0]  rf_rdata2 = '0;
  logic [XLEN-1:0]  exu_result = '0;
  logic [XLEN-1:0]  wbu_wdata = '0;
  logic [XLEN-1:0]  mem_alu_result = '0;
  logic [XLEN-1:0]  mem_rdata = '0;
  logic             mem_rdata_valid = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_src1;
  logic [XLEN-1:0]  out_src2;
  logic [CNT_W-1:0] ldu_stall_cnt;
  logic             illegal_choice;

  operand_fwd_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rs1_choice     (rs1_choice),
    .rs2_choice     (rs2_choice),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .exu_result     (exu_result),
    .wbu_wdata      (wbu_wdata),
    .mem_alu_result (mem_alu_result),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_src1       (out_src1),
    .out_src2       (out_src2),
    .ldu_stall_cnt  (ldu_stall_cnt),
    .illegal_choice (illegal_choice)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
  } pair_t;

  pair_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Model: one held instruction, which operands still wait on load data
  bit              m_busy, m_wait, m_p1, m_p2, m_ill;
  int              m_cnt;
  logic [XLEN-1:0] m_v1, m_v2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] pick(input logic [2:0] c, input logic [XLEN-1:0] rf);
    case (c)
      3'd1:    return exu_result;
      3'd2:    return wbu_wdata;
      3'd3:    return mem_rdata;
      3'd4:    return mem_alu_result;
      default: return rf;
    endcase
  endfunction

  // Monitor / scoreboard: check at the falling edge, then advance the model
  always @(negedge clk) begin : mon
    bit    e_full, e_rdy, acc;
    pair_t p;
    if (!rst_n) begin
      m_busy = 0; m_wait = 0; m_p1 = 0; m_p2 = 0; m_ill = 0; m_cnt = 0;
      q.delete();
    end else begin
      e_full = m_busy && !m_wait;
      e_rdy  = (!m_busy || (e_full && out_ready)) && !flush;
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      chk("out_valid", 64'(out_valid), 64'(e_full));
      chk("ldu_stall_cnt", 64'(ldu_stall_cnt), 64'(m_cnt));
      chk("illegal_choice", 64'(illegal_choice), 64'(m_ill));
      if (e_full) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 64'(q.size()), 64'd1);
        end else begin
          chk("out_src1", 64'(out_src1), 64'(q[0].s1));
          chk("out_src2", 64'(out_src2), 64'(q[0].s2));
          if (out_ready && !flush) void'(q.pop_front());
        end
      end
      acc = in_valid && e_rdy;
      if (flush) begin
        m_busy = 0; m_wait = 0; m_p1 = 0; m_p2 = 0;
        q.delete();
      end else if (acc) begin
        m_v1 = pick(rs1_choice, rf_rdata1);
        m_v2 = pick(rs2_choice, rf_rdata2);
        if (rs1_choice > 3'd4 || rs2_choice > 3'd4) m_ill = 1;
        m_p1   = (rs1_choice == 3'd3) && !mem_rdata_valid;
        m_p2   = (rs2_choice == 3'd3) && !mem_rdata_valid;
        m_busy = 1;
        m_wait = m_p1 || m_p2;
        if (!m_wait) begin
          p.s1 = m_v1; p.s2 = m_v2; q.push_back(p);
        end
      end else if (m_busy && m_wait) begin
        if (mem_rdata_valid) begin
          if (m_p1) m_v1 = mem_rdata;
          if (m_p2) m_v2 = mem_rdata;
          m_p1 = 0; m_p2 = 0; m_wait = 0;
          p.s1 = m_v1; p.s2 = m_v2; q.push_back(p);
        end else if (m_cnt < C_CMAX) begin
          m_cnt++;
        end
      end else if (m_busy && out_ready) begin
        m_busy = 0;
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge
  task automatic drive(input bit iv, input logic [2:0] c1, input logic [2:0] c2,
                       input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                       input logic [XLEN-1:0] ex, input logic [XLEN-1:0] alu,
                       input logic [XLEN-1:0] md, input bit mv, input bit ordy,
                       input bit fl);
    @(posedge clk);
    #1;
    in_valid = iv; rs1_choice = c1; rs2_choice = c2;
    rf_rdata1 = r1; rf_rdata2 = r2; exu_result = ex; mem_alu_result = alu;
    wbu_wdata = 32'h5A5A_0000; mem_rdata = md; mem_rdata_valid = mv;
    out_ready = ordy; flush = fl;
  endtask

  task automatic idle(input bit ordy);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, ordy, 0);
  endtask

  function automatic logic [2:0] rnd_choice();
    if ($urandom_range(0, 39) == 0) return 3'(5 + $urandom_range(0, 2));
    return 3'($urandom_range(0, 4));
  endfunction

  initial begin
    // Reset values while rst_n is held low
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_src1", 64'(out_src1), 64'd0);
    chk("rst_src2", 64'(out_src2), 64'd0);
    chk("rst_cnt", 64'(ldu_stall_cnt), 64'd0);
    chk("rst_illegal", 64'(illegal_choice), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // No hazard
    drive(1, 3'd0, 3'd0, 32'h11, 32'h22, 0, 0, 0, 0, 1, 0);
    idle(1); idle(1);
    // Forward mix: EXU and MEM-ALU
    drive(1, 3'd1, 3'd4, 32'h1, 32'h2, 32'hAA, 32'hBB, 0, 0, 1, 0);
    idle(1); idle(1);
    // Load-use on rs2 with three idle cycles before load data
    drive(1, 3'd0, 3'd3, 32'h55, 32'h66, 0, 0, 32'h1234, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 3'd0, 3'd0, 32'h9, 32'h9, 0, 0, 32'h77, 0, 1, 0);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0, 32'hDEAD, 1, 1, 0);
    idle(1); idle(1);
    // Backpressure then back-to-back accept
    drive(1, 3'd0, 3'd0, 32'h31, 32'h32, 0, 0, 0, 0, 0, 0);
    drive(1, 3'd0, 3'd0, 32'h41, 32'h42, 0, 0, 0, 0, 0, 0);
    drive(1, 3'd0, 3'd0, 32'h41, 32'h42, 0, 0, 0, 0, 0, 0);
    drive(1, 3'd0, 3'd0, 32'h51, 32'h52, 0, 0, 0, 0, 1, 0);
    idle(1); idle(1);
    // Flush while waiting on load data; later load data captures nothing
    drive(1, 3'd3, 3'd3, 32'h61, 32'h62, 0, 0, 0, 0, 1, 0);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0, 32'hBEEF, 1, 1, 0);
    idle(1); idle(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), rnd_choice(), rnd_choice(),
            $urandom, $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 24) == 0));
    end
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0, 32'hC0DE, 1, 1, 0);
    idle(1); idle(1);

    // Fresh reset, illegal code, then async reset mid-FULL
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    drive(1, 3'd6, 3'd0, 32'h77, 32'h88, 32'h99, 0, 0, 0, 0, 0);
    idle(0);
    begin : wait_full
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      chk("wait_full_timeout", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    chk("ill_src1", 64'(out_src1), 64'h77);
    chk("ill_sticky", 64'(illegal_choice), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_src1", 64'(out_src1), 64'd0);
    chk("async_src2", 64'(out_src2), 64'd0);
    chk("async_cnt", 64'(ldu_stall_cnt), 64'd0);
    chk("async_illegal", 64'(illegal_choice), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1); idle(1);
    drive(1, 3'd2, 3'd0, 32'h1, 32'h2, 0, 0, 0, 0, 1, 0);
    idle(1); idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
